// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard/stall controller for the in-order RV32 core.
//            Produces per-stage write-enable and clear vectors, handles
//            multi-cycle load-use stalls, SRAM wait stalls with a sticky
//            timeout flag, branch flushes deferred across SRAM stalls, and
//            saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_DEPTH  = 3,
    parameter int SRAM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IDEX_rdwren,
    input  logic                  IDEX_mem_rden,
    input  logic [REG_AW-1:0]     IDEX_rd,
    input  logic [REG_AW-1:0]     IFID_rs1,
    input  logic [REG_AW-1:0]     IFID_rs2,
    input  logic                  IFID_rs1_used,
    input  logic                  IFID_rs2_used,
    input  logic                  br_flush,
    input  logic                  sram_stall,
    output logic [NUM_STAGES-1:0] stage_wren,
    output logic [NUM_STAGES-1:0] stage_clear,
    output logic                  stall_active,
    output logic                  flush_active,
    output logic                  sram_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    // Wait counter only needs to reach SRAM_TIMEOUT-1.
    localparam int c_WAIT_W = (SRAM_TIMEOUT < 2) ? 1 : $clog2(SRAM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_TO_THRESH =
        c_WAIT_W'((SRAM_TIMEOUT == 0) ? 0 : SRAM_TIMEOUT - 1);
    localparam logic [2:0] c_LU_INIT = 3'(LOAD_LAT - 1);
    // Load-use bubble: freeze PC and IF/ID, clear ID/EX.
    localparam logic [NUM_STAGES-1:0] c_LU_WREN  = ~(NUM_STAGES'(3));
    localparam logic [NUM_STAGES-1:0] c_LU_CLEAR = NUM_STAGES'(4);
    // Flush clears stage indices 1..FLUSH_DEPTH.
    localparam logic [NUM_STAGES-1:0] c_FLUSH_MASK =
        NUM_STAGES'((2 ** (FLUSH_DEPTH + 1)) - 2);

    state_t                fsm_q, fsm_d;
    logic [2:0]            lu_cnt_q, lu_cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [c_WAIT_W-1:0]   sram_wait_cnt_q, sram_wait_cnt_d;
    logic                  sram_timeout_q, sram_timeout_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]      flush_count_q, flush_count_d;

    logic                  lu_hit;
    logic [NUM_STAGES-1:0] wren_d, clear_d;
    logic                  stall_d, flush_d;

    assign lu_hit = IDEX_mem_rden && IDEX_rdwren && (IDEX_rd != '0) &&
                    ((IFID_rs1_used && (IDEX_rd == IFID_rs1)) ||
                     (IFID_rs2_used && (IDEX_rd == IFID_rs2)));

    // Prioritised cycle action: SRAM stall > flush > load-use stall > normal.
    always_comb begin
        wren_d       = '1;
        clear_d      = '0;
        stall_d      = 1'b0;
        flush_d      = 1'b0;
        fsm_d        = fsm_q;
        lu_cnt_d     = lu_cnt_q;
        flush_pend_d = flush_pend_q;
        if (sram_stall) begin
            wren_d  = '0;
            stall_d = 1'b1;
            if (br_flush) begin
                flush_pend_d = 1'b1;
            end
        end else if (br_flush || flush_pend_q) begin
            clear_d      = c_FLUSH_MASK;
            flush_d      = 1'b1;
            flush_pend_d = 1'b0;
            fsm_d        = IDLE;
            lu_cnt_d     = 3'd0;
        end else if (fsm_q == LU_STALL) begin
            wren_d   = c_LU_WREN;
            clear_d  = c_LU_CLEAR;
            stall_d  = 1'b1;
            lu_cnt_d = lu_cnt_q - 3'd1;
            if (lu_cnt_q == 3'd1) begin
                fsm_d = IDLE;
            end
        end else if (lu_hit) begin
            wren_d  = c_LU_WREN;
            clear_d = c_LU_CLEAR;
            stall_d = 1'b1;
            if (LOAD_LAT > 1) begin
                fsm_d    = LU_STALL;
                lu_cnt_d = c_LU_INIT;
            end
        end
        // Reset forces every pipeline register to load and clear.
        if (rst) begin
            wren_d  = '1;
            clear_d = '1;
            stall_d = 1'b0;
            flush_d = 1'b0;
        end
    end

    // Next values for the wait counter, sticky timeout and perf counters.
    always_comb begin
        sram_wait_cnt_d = '0;
        if (sram_stall) begin
            sram_wait_cnt_d = (&sram_wait_cnt_q) ? sram_wait_cnt_q
                                                 : sram_wait_cnt_q + 1'b1;
        end
        sram_timeout_d = sram_timeout_q ||
                         ((SRAM_TIMEOUT != 0) && sram_stall &&
                          (sram_wait_cnt_q >= c_TO_THRESH));
        stall_cycles_d = stall_cycles_q;
        if (stall_d && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        flush_count_d = flush_count_q;
        if (flush_d && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    // State register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q           <= IDLE;
            lu_cnt_q        <= 3'd0;
            flush_pend_q    <= 1'b0;
            sram_wait_cnt_q <= '0;
            sram_timeout_q  <= 1'b0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
        end else begin
            fsm_q           <= fsm_d;
            lu_cnt_q        <= lu_cnt_d;
            flush_pend_q    <= flush_pend_d;
            sram_wait_cnt_q <= sram_wait_cnt_d;
            sram_timeout_q  <= sram_timeout_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign stage_wren   = wren_d;
    assign stage_clear  = clear_d;
    assign stall_active = stall_d;
    assign flush_active = flush_d;
    assign sram_timeout = sram_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed bench for hazard_ctrl. Three instances with different
//            LOAD_LAT / SRAM_TIMEOUT share one stimulus stream; expected
//            per-cycle outputs are queued when inputs are driven and popped
//            on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       IDEX_rdwren, IDEX_mem_rden;
    logic [4:0] IDEX_rd, IFID_rs1, IFID_rs2;
    logic       IFID_rs1_used, IFID_rs2_used;
    logic       br_flush, sram_stall;

    logic [2:0][4:0]  wren, clr;
    logic [2:0]       st_a, fl_a, to_f;
    logic [2:0][15:0] stc, flc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         d;
        logic [4:0] wren;
        logic [4:0] clr;
        logic       st;
        logic       fl;
        logic       to;
    } exp_t;

    exp_t  sbq[$];
    logic  exp_to [3];
    string tag;

    hazard_ctrl #(.LOAD_LAT(1), .SRAM_TIMEOUT(4)) u_d0 (
        .clk(clk), .rst(rst), .IDEX_rdwren(IDEX_rdwren), .IDEX_mem_rden(IDEX_mem_rden),
        .IDEX_rd(IDEX_rd), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_rs1_used(IFID_rs1_used), .IFID_rs2_used(IFID_rs2_used),
        .br_flush(br_flush), .sram_stall(sram_stall),
        .stage_wren(wren[0]), .stage_clear(clr[0]), .stall_active(st_a[0]),
        .flush_active(fl_a[0]), .sram_timeout(to_f[0]),
        .stall_cycles(stc[0]), .flush_count(flc[0]));

    hazard_ctrl #(.LOAD_LAT(2), .SRAM_TIMEOUT(255)) u_d1 (
        .clk(clk), .rst(rst), .IDEX_rdwren(IDEX_rdwren), .IDEX_mem_rden(IDEX_mem_rden),
        .IDEX_rd(IDEX_rd), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_rs1_used(IFID_rs1_used), .IFID_rs2_used(IFID_rs2_used),
        .br_flush(br_flush), .sram_stall(sram_stall),
        .stage_wren(wren[1]), .stage_clear(clr[1]), .stall_active(st_a[1]),
        .flush_active(fl_a[1]), .sram_timeout(to_f[1]),
        .stall_cycles(stc[1]), .flush_count(flc[1]));

    hazard_ctrl #(.LOAD_LAT(3), .SRAM_TIMEOUT(0)) u_d2 (
        .clk(clk), .rst(rst), .IDEX_rdwren(IDEX_rdwren), .IDEX_mem_rden(IDEX_mem_rden),
        .IDEX_rd(IDEX_rd), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_rs1_used(IFID_rs1_used), .IFID_rs2_used(IFID_rs2_used),
        .br_flush(br_flush), .sram_stall(sram_stall),
        .stage_wren(wren[2]), .stage_clear(clr[2]), .stall_active(st_a[2]),
        .flush_active(fl_a[2]), .sram_timeout(to_f[2]),
        .stall_cycles(stc[2]), .flush_count(flc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic push(input int d, input logic [4:0] w, input logic [4:0] c,
                        input logic st, input logic fl);
        exp_t e;
        e.d = d; e.wren = w; e.clr = c; e.st = st; e.fl = fl; e.to = exp_to[d];
        sbq.push_back(e);
    endtask

    task automatic ex_rst (input int d); push(d, 5'b11111, 5'b11111, 1'b0, 1'b0); endtask
    task automatic ex_norm(input int d); push(d, 5'b11111, 5'b00000, 1'b0, 1'b0); endtask
    task automatic ex_lu  (input int d); push(d, 5'b11100, 5'b00100, 1'b1, 1'b0); endtask
    task automatic ex_fl  (input int d); push(d, 5'b11111, 5'b01110, 1'b0, 1'b1); endtask
    task automatic ex_sram(input int d); push(d, 5'b00000, 5'b00000, 1'b1, 1'b0); endtask

    task automatic set_in(input logic wr, input logic ld, input logic [4:0] rd,
                          input logic [4:0] s1, input logic [4:0] s2,
                          input logic u1, input logic u2,
                          input logic bf, input logic ss);
        IDEX_rdwren = wr; IDEX_mem_rden = ld; IDEX_rd = rd;
        IFID_rs1 = s1; IFID_rs2 = s2; IFID_rs1_used = u1; IFID_rs2_used = u2;
        br_flush = bf; sram_stall = ss;
    endtask

    // Compare everything queued for this cycle, then advance past the edge.
    task automatic step(input string name);
        exp_t e;
        tag = name;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("%s d%0d wren", tag, e.d), 32'(wren[e.d]), 32'(e.wren));
            chk($sformatf("%s d%0d clear", tag, e.d), 32'(clr[e.d]), 32'(e.clr));
            chk($sformatf("%s d%0d stall", tag, e.d), 32'(st_a[e.d]), 32'(e.st));
            chk($sformatf("%s d%0d flush", tag, e.d), 32'(fl_a[e.d]), 32'(e.fl));
            chk($sformatf("%s d%0d timeout", tag, e.d), 32'(to_f[e.d]), 32'(e.to));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name, input int d, input int sc, input int fc);
        chk($sformatf("%s d%0d stall_cycles", name, d), 32'(stc[d]), 32'(sc));
        chk($sformatf("%s d%0d flush_count", name, d), 32'(flc[d]), 32'(fc));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) exp_to[d] = 1'b0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) ex_rst(d);
        step("reset0");
        for (int d = 0; d < 3; d++) ex_rst(d);
        step("reset1");
        rst = 1'b0;
        for (int d = 0; d < 3; d++) chk_cnt("after_reset", d, 0, 0);

        // Load x5 in ID/EX, add reading x5 through rs2.
        set_in(1, 1, 5, 1, 5, 1, 1, 0, 0);
        for (int d = 0; d < 3; d++) ex_lu(d);
        step("lu_c1");
        set_in(0, 0, 0, 1, 5, 1, 1, 0, 0);
        ex_norm(0); ex_lu(1); ex_lu(2);
        step("lu_c2");
        ex_norm(0); ex_norm(1); ex_lu(2);
        step("lu_c3");
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("lu_c4");
        chk_cnt("lu", 0, 1, 0); chk_cnt("lu", 1, 2, 0); chk_cnt("lu", 2, 3, 0);

        // Load to x0 never stalls.
        set_in(1, 1, 0, 0, 0, 1, 1, 0, 0);
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("load_x0");
        // rs2 matches but is not read.
        set_in(1, 1, 7, 3, 7, 1, 0, 0, 0);
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("rs2_unused");
        // rs1 hazard starts a stall; flush lands on its second cycle.
        set_in(1, 1, 7, 7, 2, 1, 1, 0, 0);
        for (int d = 0; d < 3; d++) ex_lu(d);
        step("rs1_hit");
        set_in(0, 0, 0, 7, 2, 1, 1, 1, 0);
        for (int d = 0; d < 3; d++) ex_fl(d);
        step("flush_in_lu");
        set_in(0, 0, 0, 7, 2, 1, 1, 0, 0);
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("after_flush");
        chk_cnt("flush_lu", 0, 2, 1); chk_cnt("flush_lu", 1, 3, 1); chk_cnt("flush_lu", 2, 4, 1);

        // Flush coinciding with a 3-cycle SRAM stall is deferred.
        set_in(0, 0, 0, 7, 2, 1, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 3; d++) ex_sram(d);
            step($sformatf("sram_fl%0d", k));
        end
        set_in(0, 0, 0, 7, 2, 1, 1, 0, 0);
        for (int d = 0; d < 3; d++) ex_fl(d);
        step("deferred_flush");
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("post_defer");
        chk_cnt("defer", 0, 5, 2); chk_cnt("defer", 1, 6, 2); chk_cnt("defer", 2, 7, 2);

        // Reset while a flush is pending discards it.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int d = 0; d < 3; d++) ex_sram(d);
        step("pend_set");
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) ex_rst(d);
        step("pend_rst");
        rst = 1'b0;
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("no_deferred");
        for (int d = 0; d < 3; d++) chk_cnt("pend_rst", d, 0, 0);

        // SRAM held 6 cycles: timeout on the TIMEOUT=4 instance after cycle 4.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            exp_to[0] = (k >= 5);
            for (int d = 0; d < 3; d++) ex_sram(d);
            step($sformatf("sram_to%0d", k));
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 3; d++) ex_norm(d);
            step("to_sticky");
        end
        for (int d = 0; d < 3; d++) chk_cnt("timeout", d, 6, 0);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) ex_rst(d);
        step("to_rst0");
        exp_to[0] = 1'b0;
        for (int d = 0; d < 3; d++) ex_rst(d);
        step("to_rst1");
        rst = 1'b0;
        for (int d = 0; d < 3; d++) ex_norm(d);
        step("to_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
